// File: rtl/pio_cpl_tx_engine.sv
// PIO completion transmitter: reads the BAR register file for a captured
// memory-read request and emits a 3DW completion on the 64-bit AXI4-Stream TX port.
module pio_cpl_tx_engine #(
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_compl,
    input  logic        req_compl_wd,
    input  logic [2:0]  req_tc,
    input  logic        req_td,
    input  logic        req_ep,
    input  logic [1:0]  req_attr,
    input  logic [9:0]  req_len,
    input  logic [15:0] req_rid,
    input  logic [7:0]  req_tag,
    input  logic [7:0]  req_be,
    input  logic [13:0] req_addr,
    input  logic [15:0] completer_id,
    output logic [13:0] rd_addr,
    output logic [3:0]  rd_be,
    input  logic [31:0] rd_data,
    input  logic        s_axis_tx_tready,
    output logic        s_axis_tx_tvalid,
    output logic [63:0] s_axis_tx_tdata,
    output logic [7:0]  s_axis_tx_tkeep,
    output logic        s_axis_tx_tlast,
    output logic [3:0]  s_axis_tx_tuser,
    output logic        compl_done
);

    localparam int unsigned CNT_W = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HDR  = 2'd2;
    localparam logic [1:0] ST_DATA = 2'd3;

    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             wd_q,      wd_d;
    logic [2:0]       tc_q,      tc_d;
    logic             td_q,      td_d;
    logic             ep_q,      ep_d;
    logic [1:0]       attr_q,    attr_d;
    logic [9:0]       len_q,     len_d;
    logic [15:0]      rid_q,     rid_d;
    logic [7:0]       tag_q,     tag_d;
    logic [31:0]      data_q,    data_d;
    logic [13:0]      rd_addr_d;
    logic [3:0]       rd_be_d;
    logic             tvalid_d;
    logic [63:0]      tdata_d;
    logic [7:0]       tkeep_d;
    logic             tlast_d;
    logic             compl_done_d;

    logic [11:0] byte_cnt;
    logic [1:0]  lo_addr;
    logic [31:0] dw0, dw1, dw2, payload;

    // last_be is meaningless for single-DW register reads
    logic unused_last_be;
    assign unused_last_be = ^req_be[7:4];

    assign s_axis_tx_tuser = 4'b0;

    // Byte count and low address bits implied by the first-DW byte enables
    always_comb begin
        byte_cnt = 12'd1;
        casez (rd_be)
            4'b1??1: byte_cnt = 12'd4;
            4'b01?1: byte_cnt = 12'd3;
            4'b1?10: byte_cnt = 12'd3;
            4'b0011: byte_cnt = 12'd2;
            4'b0110: byte_cnt = 12'd2;
            4'b1100: byte_cnt = 12'd2;
            default: byte_cnt = 12'd1;
        endcase
        lo_addr = 2'b00;
        casez (rd_be)
            4'b???1: lo_addr = 2'b00;
            4'b??10: lo_addr = 2'b01;
            4'b?100: lo_addr = 2'b10;
            4'b1000: lo_addr = 2'b11;
            default: lo_addr = 2'b00;
        endcase
    end

    // Completion header dwords and lane-swapped payload
    always_comb begin
        dw0 = {1'b0, (wd_q ? 2'b10 : 2'b00), 5'b01010, 1'b0, tc_q, 4'b0000,
               td_q, ep_q, attr_q, 2'b00, len_q};
        dw1 = {completer_id, 3'b000, 1'b0, byte_cnt};
        dw2 = {rid_q, tag_q, 1'b0, rd_addr[4:0], lo_addr};
        payload = {data_q[7:0], data_q[15:8], data_q[23:16], data_q[31:24]};
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wd_d         = wd_q;
        tc_d         = tc_q;
        td_d         = td_q;
        ep_d         = ep_q;
        attr_d       = attr_q;
        len_d        = len_q;
        rid_d        = rid_q;
        tag_d        = tag_q;
        data_d       = data_q;
        rd_addr_d    = rd_addr;
        rd_be_d      = rd_be;
        tvalid_d     = s_axis_tx_tvalid;
        tdata_d      = s_axis_tx_tdata;
        tkeep_d      = s_axis_tx_tkeep;
        tlast_d      = s_axis_tx_tlast;
        compl_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_compl) begin
                    wd_d      = req_compl_wd;
                    tc_d      = req_tc;
                    td_d      = req_td;
                    ep_d      = req_ep;
                    attr_d    = req_attr;
                    len_d     = req_len;
                    rid_d     = req_rid;
                    tag_d     = req_tag;
                    rd_addr_d = req_addr;
                    rd_be_d   = req_be[3:0];
                    cnt_d     = '0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(RD_LATENCY - 1)) begin
                    data_d   = rd_data;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    tkeep_d  = 8'hFF;
                    tdata_d  = {dw1, dw0};
                    state_d  = ST_HDR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HDR: begin
                if (s_axis_tx_tready) begin
                    tlast_d = 1'b1;
                    tdata_d = {(wd_q ? payload : 32'h0), dw2};
                    tkeep_d = wd_q ? 8'hFF : 8'h0F;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (s_axis_tx_tready) begin
                    tvalid_d     = 1'b0;
                    tlast_d      = 1'b0;
                    compl_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            wd_q             <= 1'b0;
            tc_q             <= '0;
            td_q             <= 1'b0;
            ep_q             <= 1'b0;
            attr_q           <= '0;
            len_q            <= '0;
            rid_q            <= '0;
            tag_q            <= '0;
            data_q           <= '0;
            rd_addr          <= '0;
            rd_be            <= '0;
            s_axis_tx_tvalid <= 1'b0;
            s_axis_tx_tdata  <= '0;
            s_axis_tx_tkeep  <= '0;
            s_axis_tx_tlast  <= 1'b0;
            compl_done       <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            wd_q             <= wd_d;
            tc_q             <= tc_d;
            td_q             <= td_d;
            ep_q             <= ep_d;
            attr_q           <= attr_d;
            len_q            <= len_d;
            rid_q            <= rid_d;
            tag_q            <= tag_d;
            data_q           <= data_d;
            rd_addr          <= rd_addr_d;
            rd_be            <= rd_be_d;
            s_axis_tx_tvalid <= tvalid_d;
            s_axis_tx_tdata  <= tdata_d;
            s_axis_tx_tkeep  <= tkeep_d;
            s_axis_tx_tlast  <= tlast_d;
            compl_done       <= compl_done_d;
        end
    end

endmodule

// File: tb/tb_pio_cpl_tx_engine.sv
// Scoreboard bench for pio_cpl_tx_engine: directed requests with hand-computed beats.
module tb_pio_cpl_tx_engine;

    logic        clk;
    logic        rst_n;
    logic        req_compl;
    logic        req_compl_wd;
    logic [2:0]  req_tc;
    logic        req_td;
    logic        req_ep;
    logic [1:0]  req_attr;
    logic [9:0]  req_len;
    logic [15:0] req_rid;
    logic [7:0]  req_tag;
    logic [7:0]  req_be;
    logic [13:0] req_addr;
    logic [15:0] completer_id;
    logic [13:0] rd_addr;
    logic [3:0]  rd_be;
    logic [31:0] rd_data;
    logic        s_axis_tx_tready;
    logic        s_axis_tx_tvalid;
    logic [63:0] s_axis_tx_tdata;
    logic [7:0]  s_axis_tx_tkeep;
    logic        s_axis_tx_tlast;
    logic [3:0]  s_axis_tx_tuser;
    logic        compl_done;

    pio_cpl_tx_engine #(.RD_LATENCY(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_compl        (req_compl),
        .req_compl_wd     (req_compl_wd),
        .req_tc           (req_tc),
        .req_td           (req_td),
        .req_ep           (req_ep),
        .req_attr         (req_attr),
        .req_len          (req_len),
        .req_rid          (req_rid),
        .req_tag          (req_tag),
        .req_be           (req_be),
        .req_addr         (req_addr),
        .completer_id     (completer_id),
        .rd_addr          (rd_addr),
        .rd_be            (rd_be),
        .rd_data          (rd_data),
        .s_axis_tx_tready (s_axis_tx_tready),
        .s_axis_tx_tvalid (s_axis_tx_tvalid),
        .s_axis_tx_tdata  (s_axis_tx_tdata),
        .s_axis_tx_tkeep  (s_axis_tx_tkeep),
        .s_axis_tx_tlast  (s_axis_tx_tlast),
        .s_axis_tx_tuser  (s_axis_tx_tuser),
        .compl_done       (compl_done)
    );

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    beat_t exp_q[$];
    int    checks   = 0;
    int    fails    = 0;
    int    hs_cnt   = 0;
    int    done_cnt = 0;
    int    exp_hs   = 0;
    int    exp_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pops expected beats on each handshake, checks stall stability and compl_done
    beat_t stall_b;
    bit    stall_v;
    bit    done_pend;
    always @(negedge clk) begin
        beat_t cur, e;
        cur = '{d: s_axis_tx_tdata, k: s_axis_tx_tkeep, l: s_axis_tx_tlast};
        if (!rst_n) begin
            stall_v   = 1'b0;
            done_pend = 1'b0;
        end else begin
            if (compl_done === 1'b1) done_cnt++;
            if (done_pend) begin
                checks++;
                if (compl_done !== 1'b1) begin
                    fails++;
                    $display("FAIL compl_done_pulse: got %b want 1", compl_done);
                end
                done_pend = 1'b0;
            end else if (compl_done !== 1'b0) begin
                checks++;
                fails++;
                $display("FAIL compl_done_spurious: got %b want 0", compl_done);
            end
            if (stall_v) begin
                checks++;
                if (s_axis_tx_tvalid !== 1'b1 || cur !== stall_b) begin
                    fails++;
                    $display("FAIL stall_stable: got v=%b d=%h k=%h l=%b want v=1 d=%h k=%h l=%b",
                             s_axis_tx_tvalid, cur.d, cur.k, cur.l, stall_b.d, stall_b.k, stall_b.l);
                end
            end
            if (s_axis_tx_tvalid === 1'b1 && s_axis_tx_tready === 1'b1) begin
                hs_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL beat_unexpected: got d=%h k=%h l=%b want none", cur.d, cur.k, cur.l);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        fails++;
                        $display("FAIL beat: got d=%h k=%h l=%b want d=%h k=%h l=%b",
                                 cur.d, cur.k, cur.l, e.d, e.k, e.l);
                    end
                end
                if (s_axis_tx_tlast === 1'b1) done_pend = 1'b1;
                stall_v = 1'b0;
            end else if (s_axis_tx_tvalid === 1'b1) begin
                stall_v = 1'b1;
                stall_b = cur;
            end else begin
                stall_v = 1'b0;
            end
        end
    end

    // One request: drive fields, model the register-file latency, pace tready
    task automatic run_pkt(input logic wd, input logic [2:0] tc, input logic td, input logic ep,
                           input logic [1:0] attr, input logic [9:0] len, input logic [15:0] rid,
                           input logic [7:0] tag, input logic [7:0] be, input logic [13:0] addr,
                           input logic [15:0] cid, input logic [31:0] data,
                           input logic [63:0] e_hdr, input logic [63:0] e_dat,
                           input int hs, input int ds, input bit abort);
        int  h, d;
        bit  fin;
        h = 0; d = 0; fin = 1'b0;
        exp_q.push_back('{d: e_hdr, k: 8'hFF, l: 1'b0});
        exp_q.push_back('{d: e_dat, k: (wd ? 8'hFF : 8'h0F), l: 1'b1});
        exp_hs   += abort ? 1 : 2;
        exp_done += abort ? 0 : 1;
        req_compl = 1'b1; req_compl_wd = wd; req_tc = tc; req_td = td; req_ep = ep;
        req_attr = attr; req_len = len; req_rid = rid; req_tag = tag; req_be = be;
        req_addr = addr; completer_id = cid; rd_data = $urandom;
        s_axis_tx_tready = (hs == 0);
        @(posedge clk); #1;
        req_compl = 1'b0;
        {req_compl_wd, req_tc, req_td, req_ep, req_attr} = 8'($urandom);
        req_len = 10'($urandom); req_rid = 16'($urandom); req_tag = 8'($urandom);
        req_be = 8'($urandom); req_addr = 14'($urandom);
        checks++;
        if (rd_addr !== addr || rd_be !== be[3:0]) begin
            fails++;
            $display("FAIL rd_port: got addr=%h be=%h want addr=%h be=%h", rd_addr, rd_be, addr, be[3:0]);
        end
        for (int k = 0; k < 100 && !fin; k++) begin
            rd_data = (k == 1) ? data : $urandom;
            if (s_axis_tx_tvalid === 1'b1 && s_axis_tx_tlast === 1'b0) begin
                if (h < hs) begin s_axis_tx_tready = 1'b0; h++; end
                else s_axis_tx_tready = 1'b1;
            end else if (s_axis_tx_tvalid === 1'b1) begin
                if (abort && d >= 1) begin
                    void'(exp_q.pop_back());
                    rst_n = 1'b0;
                    @(posedge clk); #1;
                    checks++;
                    if (s_axis_tx_tvalid !== 1'b0 || compl_done !== 1'b0 || s_axis_tx_tlast !== 1'b0) begin
                        fails++;
                        $display("FAIL abort_reset: got v=%b l=%b done=%b want 0 0 0",
                                 s_axis_tx_tvalid, s_axis_tx_tlast, compl_done);
                    end
                    rst_n = 1'b1;
                    fin = 1'b1;
                end else if (d < ds) begin
                    s_axis_tx_tready = 1'b0; d++;
                end else begin
                    s_axis_tx_tready = 1'b1;
                end
            end else begin
                s_axis_tx_tready = 1'($urandom);
            end
            if (!fin) begin
                @(posedge clk); #1;
                if (compl_done === 1'b1) fin = 1'b1;
            end
        end
        if (!fin) begin
            checks++;
            fails++;
            $display("FAIL timeout: tag=%h got no compl_done want compl_done", tag);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_compl = 1'b0; req_compl_wd = 1'b0; req_tc = '0; req_td = 1'b0;
        req_ep = 1'b0; req_attr = '0; req_len = '0; req_rid = '0; req_tag = '0; req_be = '0;
        req_addr = '0; completer_id = '0; rd_data = '0; s_axis_tx_tready = 1'b1;
        stall_v = 1'b0; done_pend = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (s_axis_tx_tvalid !== 1'b0 || s_axis_tx_tlast !== 1'b0 || s_axis_tx_tdata !== 64'h0 ||
            s_axis_tx_tkeep !== 8'h0 || compl_done !== 1'b0 || rd_addr !== 14'h0 ||
            rd_be !== 4'h0 || s_axis_tx_tuser !== 4'h0) begin
            fails++;
            $display("FAIL reset_state: got v=%b l=%b d=%h k=%h done=%b a=%h be=%h u=%h want all 0",
                     s_axis_tx_tvalid, s_axis_tx_tlast, s_axis_tx_tdata, s_axis_tx_tkeep,
                     compl_done, rd_addr, rd_be, s_axis_tx_tuser);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // wd tc td ep attr len rid tag be addr cid data hdr dat hs ds abort
        run_pkt(1, 0, 0, 0, 0, 10'd1, 16'h0100, 8'h05, 8'h0F, 14'h0001, 16'h0300, 32'h00000040,
                64'h03000004_4A000001, 64'h40000000_01000504, 0, 0, 0);
        run_pkt(1, 0, 0, 0, 0, 10'd1, 16'h0100, 8'h06, 8'h0F, 14'h0001, 16'h0300, 32'h12345678,
                64'h03000004_4A000001, 64'h78563412_01000604, 5, 3, 0);
        run_pkt(1, 0, 0, 0, 0, 10'd1, 16'h0100, 8'h07, 8'h04, 14'h0003, 16'h0300, 32'hAABBCCDD,
                64'h03000001_4A000001, 64'hDDCCBBAA_0100070E, 0, 0, 0);
        run_pkt(1, 0, 0, 0, 0, 10'd1, 16'h0100, 8'h08, 8'h0C, 14'h0010, 16'h0300, 32'h01020304,
                64'h03000002_4A000001, 64'h04030201_01000842, 1, 0, 0);
        run_pkt(1, 0, 0, 0, 0, 10'd1, 16'h0100, 8'h09, 8'hF0, 14'h1005, 16'h0300, 32'hDEADBEEF,
                64'h03000001_4A000001, 64'hEFBEADDE_01000914, 0, 2, 0);
        run_pkt(0, 0, 0, 0, 0, 10'd1, 16'h0100, 8'h0A, 8'h0F, 14'h0002, 16'h0300, 32'h87654321,
                64'h03000004_0A000001, 64'h00000000_01000A08, 0, 0, 0);
        run_pkt(1, 3'd5, 1, 1, 2'd2, 10'h3FF, 16'hABCD, 8'hFF, 8'h07, 14'h2FFF, 16'h1234, 32'hCAFEF00D,
                64'h12340003_4A50E3FF, 64'h0DF0FECA_ABCDFF7C, 2, 1, 0);
        run_pkt(1, 0, 0, 0, 0, 10'd1, 16'h0100, 8'h0B, 8'h02, 14'h0000, 16'h0300, 32'h11223344,
                64'h03000001_4A000001, 64'h44332211_01000B01, 0, 0, 0);
        run_pkt(1, 0, 0, 0, 0, 10'd1, 16'h0100, 8'h0C, 8'h08, 14'h0000, 16'h0300, 32'h55667788,
                64'h03000001_4A000001, 64'h88776655_01000C03, 0, 0, 0);
        run_pkt(1, 0, 0, 0, 0, 10'd1, 16'h0100, 8'h0D, 8'h0E, 14'h0000, 16'h0300, 32'h99AABBCC,
                64'h03000003_4A000001, 64'hCCBBAA99_01000D01, 0, 0, 0);
        run_pkt(1, 0, 0, 0, 0, 10'd1, 16'h0100, 8'h0E, 8'h0F, 14'h0001, 16'h0300, 32'h0BADF00D,
                64'h03000004_4A000001, 64'h0DF0AD0B_01000E04, 0, 4, 1);
        run_pkt(1, 0, 0, 0, 0, 10'd1, 16'h0100, 8'h05, 8'h0F, 14'h0001, 16'h0300, 32'h00000040,
                64'h03000004_4A000001, 64'h40000000_01000504, 0, 0, 0);
        run_pkt(0, 0, 0, 0, 0, 10'd1, 16'h0100, 8'h0A, 8'h0F, 14'h0002, 16'h0300, 32'h87654321,
                64'h03000004_0A000001, 64'h00000000_01000A08, 0, 0, 0);

        s_axis_tx_tready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain: got %0d beats left want 0", exp_q.size());
        end
        checks++;
        if (hs_cnt != exp_hs) begin
            fails++;
            $display("FAIL handshake_count: got %0d want %0d", hs_cnt, exp_hs);
        end
        checks++;
        if (done_cnt != exp_done) begin
            fails++;
            $display("FAIL done_count: got %0d want %0d", done_cnt, exp_done);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Watchdog bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test want end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
